// File: rtl/rv32im_pkg.sv
// Shared types for the data-memory port arbiter and related memory-path blocks.
package rv32im_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  typedef enum logic {
    ARB   = 1'b0,
    DLOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_range_check.sv
// Combinational DMEM window decode: byte address -> hit flag and word index.
// The offset is taken with 32-bit wrap so addresses below the base land far
// above the window and miss.
module dmem_range_check #(
  parameter int unsigned SIZE_POW2 = 9,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic [31:0]          i_addr,
  output logic                 o_hit,
  output logic [SIZE_POW2-3:0] o_widx
);

  logic [31:0] w_off;

  assign w_off  = i_addr - BASE_ADDR;
  assign o_hit  = (w_off >> SIZE_POW2) == 32'd0;
  assign o_widx = w_off[SIZE_POW2-1:2];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port DMEM between the CPU MEM stage (C) and a debug/DMA
// master (D). C has fixed priority, D wins after MAX_WAIT denied cycles, and
// D may lock the port for bursts. Responses come back one cycle after grant.
module dmem_port_arbiter
  import rv32im_pkg::*;
#(
  parameter int unsigned DMEM_SIZE_POW2 = 9,
  parameter logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MAX_WAIT       = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      c_req,
  input  logic                      c_we,
  input  logic [31:0]               c_addr,
  input  logic [31:0]               c_wdata,
  input  logic [3:0]                c_be,
  output logic                      c_gnt,
  output logic                      c_rvalid,
  output logic [31:0]               c_rdata,
  output logic                      c_err,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [31:0]               d_addr,
  input  logic [31:0]               d_wdata,
  input  logic [3:0]                d_be,
  input  logic                      d_lock,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [31:0]               d_rdata,
  output logic                      d_err,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [DMEM_SIZE_POW2-3:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_be,
  input  logic [31:0]               mem_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  arb_state_t            r_state, w_state_nxt;
  logic [WCW-1:0]        r_wait_cnt;
  logic                  r_rsp_c, r_rsp_d, r_rsp_we, r_rsp_err;
  dmem_req_t             w_c_req, w_d_req, w_win;
  dmem_rsp_t             w_rsp;
  logic                  w_hit, w_any_gnt, w_d_prio;
  logic [DMEM_SIZE_POW2-3:0] w_widx;

  assign w_c_req   = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be};
  assign w_d_req   = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
  assign w_d_prio  = (r_wait_cnt == WCW'(MAX_WAIT));
  assign w_any_gnt = c_gnt | d_gnt;
  assign w_win     = c_gnt ? w_c_req : w_d_req;

  dmem_range_check #(
    .SIZE_POW2 (DMEM_SIZE_POW2),
    .BASE_ADDR (DMEM_BASE_ADDR)
  ) u_range (
    .i_addr (w_win.addr),
    .o_hit  (w_hit),
    .o_widx (w_widx)
  );

  // Arbiter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ARB;
    else          r_state <= w_state_nxt;
  end

  // Next state: lock on a locked D beat, release on the final beat or when D goes idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (d_gnt && d_lock) w_state_nxt = DLOCK;
      DLOCK:   if (!d_req || (d_gnt && !d_lock)) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // Grants: C first unless D has starved long enough; only D while locked; none in reset
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset_n) begin
      case (r_state)
        ARB: begin
          c_gnt = c_req && !(d_req && w_d_prio);
          d_gnt = d_req && !c_gnt;
        end
        DLOCK:   d_gnt = d_req;
        default: ;
      endcase
    end
  end

  // Starvation counter: counts denied D cycles, saturates, clears on a D grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_wait_cnt <= '0;
    else if (d_gnt)                                r_wait_cnt <= '0;
    else if (d_req && r_wait_cnt != WCW'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + WCW'(1);
  end

  // Memory strobe only for in-window grants; all mem_* held at 0 otherwise
  always_comb begin
    mem_en    = w_any_gnt && w_hit;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_en) begin
      mem_we    = w_win.we;
      mem_addr  = w_widx;
      mem_wdata = w_win.wdata;
      mem_be    = w_win.be;
    end
  end

  // Response bookkeeping: owner, kind and error of this cycle's grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_c   <= 1'b0;
      r_rsp_d   <= 1'b0;
      r_rsp_we  <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_c   <= c_gnt;
      r_rsp_d   <= d_gnt;
      r_rsp_we  <= w_win.we;
      r_rsp_err <= !w_hit;
    end
  end

  // Response steering: read data only for in-window reads, routed to the recorded owner
  always_comb begin
    w_rsp.rvalid = r_rsp_c | r_rsp_d;
    w_rsp.err    = w_rsp.rvalid && r_rsp_err;
    w_rsp.rdata  = (w_rsp.rvalid && !r_rsp_err && !r_rsp_we) ? mem_rdata : 32'd0;
    c_rvalid     = r_rsp_c;
    c_rdata      = r_rsp_c ? w_rsp.rdata : 32'd0;
    c_err        = r_rsp_c && w_rsp.err;
    d_rvalid     = r_rsp_d;
    d_rdata      = r_rsp_d ? w_rsp.rdata : 32'd0;
    d_err        = r_rsp_d && w_rsp.err;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-enabled DMEM model and a
// golden image; expected responses are queued at grant time and popped a cycle later.
module tb_dmem_port_arbiter;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_be, d_be;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] dmem [128];
  logic [31:0] gold [128];
  bit          loaded = 1'b0;

  typedef struct {
    logic        cv;
    logic [31:0] cd;
    logic        ce;
    logic        dv;
    logic [31:0] dd;
    logic        de;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .DMEM_SIZE_POW2 (9),
    .DMEM_BASE_ADDR (BASE),
    .MAX_WAIT       (8)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .c_req (c_req), .c_we (c_we), .c_addr (c_addr), .c_wdata (c_wdata), .c_be (c_be),
    .c_gnt (c_gnt), .c_rvalid (c_rvalid), .c_rdata (c_rdata), .c_err (c_err),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata), .d_be (d_be),
    .d_lock (d_lock),
    .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata), .d_err (d_err),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_be (mem_be), .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] pat(int i);
    return {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
  endfunction

  // DMEM model: preload once, then synchronous byte-enabled write / registered read
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 128; i++) dmem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= dmem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return {c_gnt, c_rvalid, c_rdata, c_err, d_gnt, d_rvalid, d_rdata, d_err,
            mem_en, mem_we, mem_addr, mem_wdata, mem_be};
  endfunction

  // One cycle: check last cycle's response, check this cycle's grant and memory strobe
  task automatic tick(input bit ecg, input bit edg);
    exp_t        e, n;
    logic        we, hit;
    logic [31:0] a, wd, off;
    logic [3:0]  be;
    logic [44:0] em;
    @(negedge clk);
    e = '{cv: 0, cd: 0, ce: 0, dv: 0, dd: 0, de: 0};
    if (q.size() > 0) e = q.pop_front();
    chk("c_rsp", {c_rvalid, c_rdata, c_err}, {e.cv, e.cd, e.ce});
    chk("d_rsp", {d_rvalid, d_rdata, d_err}, {e.dv, e.dd, e.de});
    chk("gnt", {c_gnt, d_gnt}, {ecg, edg});
    n  = '{cv: 0, cd: 0, ce: 0, dv: 0, dd: 0, de: 0};
    em = '0;
    if (ecg || edg) begin
      we  = ecg ? c_we    : d_we;
      a   = ecg ? c_addr  : d_addr;
      wd  = ecg ? c_wdata : d_wdata;
      be  = ecg ? c_be    : d_be;
      off = a - BASE;
      hit = off < 32'd512;
      if (hit) begin
        em = {1'b1, we, off[8:2], wd, be};
        if (we)
          for (int b = 0; b < 4; b++)
            if (be[b]) gold[off[8:2]][8*b +: 8] = wd[8*b +: 8];
      end
      if (ecg) begin
        n.cv = 1'b1; n.ce = !hit; n.cd = (hit && !we) ? gold[off[8:2]] : 32'd0;
      end else begin
        n.dv = 1'b1; n.de = !hit; n.dd = (hit && !we) ? gold[off[8:2]] : 32'd0;
      end
    end
    chk("mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, em);
    q.push_back(n);
    @(posedge clk); #1;
  endtask

  task automatic set_c(input bit req, input bit we, input logic [31:0] a, input logic [31:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_be = 4'hF;
  endtask

  task automatic set_d(input bit req, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit lk);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_be = be; d_lock = lk;
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 128; i++) gold[i] = pat(i);
    reset_n = 1'b0;
    set_c(0, 0, 0, 0);
    set_d(0, 0, 0, 0, 4'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_idle", all_out(), '0);
    set_c(1, 0, BASE + 32'h10, 0);
    #1 chk("reset_req", all_out(), '0);
    set_c(0, 0, 0, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // single CPU read, word index 4
    set_c(1, 0, BASE + 32'h10, 0); tick(1, 0);
    set_c(0, 0, 0, 0);             tick(0, 0);

    // program run: CPU writes, a partial debug write, back-to-back readback
    for (int i = 0; i < 6; i++) begin
      set_c(1, 1, BASE + 32'(i * 28), $urandom); tick(1, 0);
    end
    set_c(0, 0, 0, 0);
    set_d(1, 1, BASE + 32'h8, 32'h1234_5678, 4'b0101, 0); tick(0, 1);
    set_d(0, 0, 0, 0, 4'h0, 0);
    set_c(1, 0, BASE + 32'h8, 0);   tick(1, 0);
    set_c(1, 0, BASE + 32'h1FC, 0); tick(1, 0);

    // window boundaries: just above the top, just below the base
    set_c(1, 1, BASE + 32'h200, 32'hDEAD_BEEF); tick(1, 0);
    set_c(1, 1, 32'h7FFF_FFFC, 32'hDEAD_BEEF);  tick(1, 0);
    set_c(0, 0, 0, 0);
    set_d(1, 0, 32'h0, 0, 4'hF, 0);             tick(0, 1);
    set_d(0, 0, 0, 0, 4'h0, 0);                 tick(0, 0);

    // contention: D starves 8 cycles then wins, twice
    set_c(1, 0, BASE + 32'h20, 0);
    set_d(1, 0, BASE + 32'h40, 0, 4'hF, 0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) tick(1, 0);
      tick(0, 1);
    end
    set_d(0, 0, 0, 0, 4'h0, 0); tick(1, 0);
    set_c(0, 0, 0, 0);          tick(0, 0);

    // locked debug burst: C blocked for all four beats, granted the cycle after
    set_c(1, 0, BASE + 32'h30, 0);
    set_d(1, 1, BASE + 32'h100, $urandom, 4'hF, 1);
    for (int k = 0; k < 8; k++) tick(1, 0);
    for (int k = 0; k < 4; k++) begin
      set_d(1, 1, BASE + 32'h100 + 32'(4 * k), $urandom, 4'hF, k < 3);
      tick(0, 1);
    end
    set_d(0, 0, 0, 0, 4'h0, 0); tick(1, 0);
    set_c(0, 0, 0, 0);          tick(0, 0);

    // lock released when D drops its request mid-burst
    set_d(1, 1, BASE + 32'h140, 32'h0BAD_F00D, 4'hF, 1); tick(0, 1);
    set_c(1, 0, BASE + 32'h30, 0);
    set_d(1, 0, BASE + 32'h144, 0, 4'hF, 1);              tick(0, 1);
    set_d(0, 0, 0, 0, 4'h0, 0);                           tick(0, 0);
    tick(1, 0);
    set_c(0, 0, 0, 0);                                    tick(0, 0);

    // reset between grant and response drops the response
    set_c(1, 0, BASE + 32'h10, 0);
    @(negedge clk);
    chk("pre_rst_rsp", {c_rvalid, d_rvalid}, 2'b00);
    chk("pre_rst_gnt", {c_gnt, d_gnt}, 2'b10);
    reset_n = 1'b0;
    #1 chk("rst_async", all_out(), '0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", all_out(), '0);
    q.delete();
    set_c(0, 0, 0, 0);
    reset_n = 1'b1;
    tick(0, 0);
    tick(0, 0);

    // dump the whole DMEM through D
    for (int i = 0; i < 128; i++) begin
      set_d(1, 0, BASE + 32'(4 * i), 0, 4'hF, 0); tick(0, 1);
    end
    set_d(0, 0, 0, 0, 4'h0, 0); tick(0, 0);

    bad = 0;
    for (int i = 0; i < 128; i++) if (dmem[i] !== gold[i]) bad++;
    chk("dmem_image", 128'(bad), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
